muldiv_hilo_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural Hi/Lo registers, replacing the single-cycle Hi/Lo write path in the EX stage of the pipelined datapath. Accepts an operation from EX on a one-cycle Start strobe and computes over WIDTH+1 cycles. It raises Stall to the hazard logic while an mfhi/mflo-class read is in EX and a result is pending. Adds signed/unsigned divide, multiply-accumulate, abort on pipeline flush, and divide-by-zero flagging.

---
 rtl/muldiv_hilo_unit.sv | 218 +++++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural Hi/Lo registers.
// One radix-2 step per cycle; sign handling is done once at load and once at FIX.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             hilo_read_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // state | meaning
  // IDLE  | waiting for start; mthi/mtlo handled here directly
  // CALC  | one shift-add / restoring-divide step per cycle
  // FIX   | sign correction and Hi/Lo write
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               in_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               op_is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_s, hilo_sum, hilo_diff;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_by_zero;

  assign in_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign in_signed = (op_i == OP_MULT) || (op_i == OP_DIV) ||
                     (op_i == OP_MADD) || (op_i == OP_MSUB);
  assign a_neg     = in_signed & src_a_i[WIDTH-1];
  assign b_neg     = in_signed & src_b_i[WIDTH-1];
  assign a_mag     = a_neg ? -src_a_i : src_a_i;
  assign b_mag     = b_neg ? -src_b_i : src_b_i;

  assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Multiply: {acc_hi, acc_lo} shifts right, multiplier bits consumed from acc_lo[0].
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: dividend bits shift out of acc_lo into the partial remainder in acc_hi.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

  assign prod_mag    = {acc_hi_q, acc_lo_q};
  assign prod_s      = neg_lo_q ? -prod_mag : prod_mag;
  assign hilo_sum    = {hi_q, lo_q} + prod_s;
  assign hilo_diff   = {hi_q, lo_q} - prod_s;
  assign quot        = neg_lo_q ? -acc_lo_q : acc_lo_q;
  assign rem         = neg_hi_q ? -acc_hi_q : acc_hi_q;
  assign div_by_zero = (opnd_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          if (op_i == OP_MTHI) begin
            hi_d   = src_a_i;
            done_d = 1'b1;
          end else if (op_i == OP_MTLO) begin
            lo_d   = src_a_i;
            done_d = 1'b1;
          end else begin
            op_d     = op_i;
            a_d      = src_a_i;
            acc_hi_d = '0;
            cnt_d    = CNT_LAST;
            state_d  = ST_CALC;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            acc_lo_d = in_div ? a_mag : b_mag;
            opnd_d   = in_div ? b_mag : a_mag;
          end
        end
      end

      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          if (op_is_div) begin
            acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
            OP_MADD:           {hi_d, lo_d} = hilo_sum;
            OP_MSUB:           {hi_d, lo_d} = hilo_diff;
            OP_DIV, OP_DIVU: begin
              // Divide by zero keeps the dividend in Hi and saturates Lo.
              if (div_by_zero) begin
                hi_d = a_q;
                lo_d = '1;
                dz_d = 1'b1;
              end else begin
                hi_d = rem;
                lo_d = quot;
                dz_d = 1'b0;
              end
            end
            default: done_d = 1'b0;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign stall_o    = hilo_read_i & busy_o;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: expected Hi/Lo/DivZero pushed at issue,
// popped and compared by a monitor whenever Done is seen.
module tb_muldiv_hilo_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, flush, hilo_read;
  logic [2:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          busy, stall, done, div_zero;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;

  logic [64:0]   exp_q[$];
  logic [31:0]   m_hi = '0, m_lo = '0;
  logic          m_dz = 1'b0;

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush), .hilo_read_i(hilo_read),
    .busy_o(busy), .stall_o(stall), .done_o(done), .div_zero_o(div_zero),
    .hi_o(hi), .lo_o(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural Hi/Lo state.
  task automatic model_push(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint    p;
    logic [63:0] hl;
    int        sa, sb;
    p  = longint'($signed(a)) * longint'($signed(b));
    hl = {m_hi, m_lo};
    case (o)
      3'b000: hl = 64'(p);
      3'b001: hl = {32'b0, a} * {32'b0, b};
      3'b100: hl = hl + 64'(p);
      3'b101: hl = hl - 64'(p);
      default: ;
    endcase
    case (o)
      3'b000, 3'b001, 3'b100, 3'b101: begin m_hi = hl[63:32]; m_lo = hl[31:0]; end
      3'b010, 3'b011: begin
        if (b == 0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1;
        end else if (o == 3'b011) begin
          m_lo = a / b; m_hi = a % b; m_dz = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 0; m_dz = 1'b0;
        end else begin
          sa = a; sb = b;
          m_lo = sa / sb; m_hi = sa % sb; m_dz = 1'b0;
        end
      end
      3'b110: m_hi = a;
      3'b111: m_lo = a;
      default: ;
    endcase
    exp_q.push_back({m_dz, m_hi, m_lo});
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e[63:32]));
        check("result_lo", 64'(lo), 64'(e[31:0]));
        check("result_divzero", 64'(div_zero), 64'(e[64]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_res, input bit with_flush);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got busy=%b expected 0", busy);
    end
    start = 1'b1; op = o; src_a = a; src_b = b; flush = with_flush;
    if (expect_res && !with_flush) model_push(o, a, b);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    int n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      n++;
      @(negedge clk);
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: got done=%b expected 1", done);
    end
  endtask

  initial begin
    int bc;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_read = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_divzero", 64'(div_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // mult -3*7 with Hi/Lo read pending for the whole operation
    issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1, 0);
    hilo_read = 1'b1;
    #1 check("stall_while_busy", 64'(stall), 64'(1));
    wait_done(bc);
    check("mult_busy_cycles", 64'(bc), 64'(W + 1));
    check("busy_in_done_cycle", 64'(busy), 64'(0));
    check("stall_in_done_cycle", 64'(stall), 64'(0));
    hilo_read = 1'b0;
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'(0));

    // divu then back-to-back signed div in the Done cycle
    issue(3'b011, 32'd100, 32'd7, 1, 0);
    wait_done(bc);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 0);
    wait_done(bc);
    check("b2b_busy_cycles", 64'(bc), 64'(W + 1));

    issue(3'b010, 32'd5, 32'd0, 1, 0);
    wait_done(bc);
    issue(3'b001, 32'd3, 32'd4, 1, 0);
    wait_done(bc);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_done(bc);

    // mtlo/mthi then multiply-accumulate carry/borrow across Hi/Lo
    issue(3'b111, 32'hFFFF_FFFF, 32'd0, 1, 0);
    wait_done(bc);
    check("mtlo_busy_cycles", 64'(bc), 64'(0));
    issue(3'b110, 32'd0, 32'd0, 1, 0);
    wait_done(bc);
    issue(3'b100, 32'd1, 32'd1, 1, 0);
    wait_done(bc);
    issue(3'b101, 32'd2, 32'd1, 1, 0);
    wait_done(bc);
    @(negedge clk);

    // flush mid-operation; a Start while busy must be ignored
    issue(3'b000, 32'h1234_5678, 32'd3, 0, 0);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 3'b001; src_a = 32'd9; src_b = 32'd9; hilo_read = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("stall_hiloread", 64'(stall), 64'(1));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_stall", 64'(stall), 64'(0));
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    hilo_read = 1'b0;
    repeat (40) @(negedge clk);

    // flush in the FIX cycle
    issue(3'b001, 32'd11, 32'd13, 0, 0);
    repeat (W) @(negedge clk);
    check("fix_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fixflush_busy", 64'(busy), 64'(0));
    check("fixflush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);

    // flush with start in IDLE: both mthi and mult are dropped
    issue(3'b110, 32'hDEAD_BEEF, 32'd0, 1, 1);
    check("flush_start_busy", 64'(busy), 64'(0));
    issue(3'b000, 32'd5, 32'd5, 1, 1);
    check("flush_mult_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

    // reset mid-divide
    issue(3'b010, 32'd1000, 32'd3, 0, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    check("rst_divzero", 64'(div_zero), 64'(0));
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_done(bc);

    // random mix, issued back-to-back in each Done cycle
    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 20));
        2: r_b = -32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      issue(r_op, r_a, r_b, 1, 0);
      wait_done(bc);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
